// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//
// Each requester offers an operation (ctl, a, b) with a valid; when granted,
// the operands are driven onto the shared ALU port in the same cycle and the
// ALU result and flags are captured into that requester's one-entry response
// register on the closing clock edge.
//
// Arbitration build option:
//   ALU_ARBITER_FIXED_PRIO_EN defined   : req0 wins contention, with a starvation
//                                         counter forcing a req1 win after
//                                         STARVE_MAX lost cycles.
//   ALU_ARBITER_FIXED_PRIO_EN undefined : round-robin via a 1-bit pointer
//                                         (default).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake (N = 0, 1)
//   reqN_ctl, reqN_a, reqN_b    ALU control code and operands
//   rspN_valid/ready            response handshake
//   rspN_data, rspN_zero/lt/ltu captured ALU result and flags
//   alu_ctl, alu_a, alu_b       shared ALU inputs (0 when idle)
//   alu_out, alu_zero/lt/ltu    shared ALU result and flags
module alu_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_zero,
  output logic        rsp0_lt,
  output logic        rsp0_ltu,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_zero,
  output logic        rsp1_lt,
  output logic        rsp1_ltu,

  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu
);

  localparam logic RspEmpty = 1'b0;
  localparam logic RspFull  = 1'b1;

  logic        rsp0_state_q, rsp0_state_d;
  logic        rsp1_state_q, rsp1_state_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;
  logic [2:0]  rsp0_flags_q, rsp0_flags_d;  // {zero, lt, ltu}
  logic [2:0]  rsp1_flags_q, rsp1_flags_d;

  logic elig0, elig1;
  logic grant0, grant1;
  logic prefer1;  // winner under contention: 1 selects req1

  // A requester may only issue if its response slot is free or draining now.
  // Gating with rst_n keeps the handshake and ALU port quiet while in reset.
  assign elig0 = rst_n & req0_valid & ((rsp0_state_q == RspEmpty) | rsp0_ready);
  assign elig1 = rst_n & req1_valid & ((rsp1_state_q == RspEmpty) | rsp1_ready);

  assign grant0 = elig0 & (~elig1 | ~prefer1);
  assign grant1 = elig1 & (~elig0 | prefer1);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  logic [7:0] starve_cnt_q, starve_cnt_d;

  assign prefer1 = (starve_cnt_q >= 8'(STARVE_MAX));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant1) begin
      starve_cnt_d = 8'd0;
    end else if (elig1 && (starve_cnt_q != 8'hff)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic ptr_q, ptr_d;

  assign prefer1 = ptr_q;

  // After any grant the pointer favours the requester that did not win.
  always_comb begin
    ptr_d = ptr_q;
    if (grant0) begin
      ptr_d = 1'b1;
    end else if (grant1) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Shared ALU port: driven only by the granted requester, zero when idle.
  always_comb begin
    alu_ctl = 4'd0;
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    if (grant0) begin
      alu_ctl = req0_ctl;
      alu_a   = req0_a;
      alu_b   = req0_b;
    end else if (grant1) begin
      alu_ctl = req1_ctl;
      alu_a   = req1_a;
      alu_b   = req1_b;
    end
  end

  // Response slots: a grant loads new data (even while draining); otherwise a
  // consumer ready empties the slot. Data is left untouched when not loading.
  always_comb begin
    rsp0_state_d = rsp0_state_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_flags_d = rsp0_flags_q;
    if (grant0) begin
      rsp0_state_d = RspFull;
      rsp0_data_d  = alu_out;
      rsp0_flags_d = {alu_zero, alu_lt, alu_ltu};
    end else if (rsp0_ready) begin
      rsp0_state_d = RspEmpty;
    end
  end

  always_comb begin
    rsp1_state_d = rsp1_state_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_flags_d = rsp1_flags_q;
    if (grant1) begin
      rsp1_state_d = RspFull;
      rsp1_data_d  = alu_out;
      rsp1_flags_d = {alu_zero, alu_lt, alu_ltu};
    end else if (rsp1_ready) begin
      rsp1_state_d = RspEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_state_q <= RspEmpty;
      rsp1_state_q <= RspEmpty;
      rsp0_data_q  <= 32'd0;
      rsp1_data_q  <= 32'd0;
      rsp0_flags_q <= 3'd0;
      rsp1_flags_q <= 3'd0;
    end else begin
      rsp0_state_q <= rsp0_state_d;
      rsp1_state_q <= rsp1_state_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp0_flags_q <= rsp0_flags_d;
      rsp1_flags_q <= rsp1_flags_d;
    end
  end

  assign rsp0_valid = (rsp0_state_q == RspFull);
  assign rsp1_valid = (rsp1_state_q == RspFull);
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign {rsp0_zero, rsp0_lt, rsp0_ltu} = rsp0_flags_q;
  assign {rsp1_zero, rsp1_lt, rsp1_ltu} = rsp1_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (default round-robin build). A small
// behavioural ALU answers the shared port; every expected value is a
// hand-computed constant. Inputs change on the falling edge, outputs are
// sampled 1 time unit later.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [3:0]  req0_ctl, req1_ctl, alu_ctl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_out;
  logic        rsp0_zero, rsp0_lt, rsp0_ltu, rsp1_zero, rsp1_lt, rsp1_ltu;
  logic        alu_zero, alu_lt, alu_ltu;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_zero(rsp0_zero), .rsp0_lt(rsp0_lt), .rsp0_ltu(rsp0_ltu),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_zero(rsp1_zero), .rsp1_lt(rsp1_lt), .rsp1_ltu(rsp1_ltu),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu)
  );

  // External ALU: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT.
  always_comb begin
    case (alu_ctl)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);
  assign alu_lt   = $signed(alu_a) < $signed(alu_b);
  assign alu_ltu  = alu_a < alu_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with a request already offered: nothing may be granted.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
    req1_valid = 1'b0; req1_ctl = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp0_data", rsp0_data, 0);

    // Single requester ADD 5+7.
    @(negedge clk);
    rst_n = 1'b1; rsp0_ready = 1'b1;
    #1;
    chk("add_req0_ready", req0_ready, 1);
    chk("add_req1_ready", req1_ready, 0);
    chk("add_alu_ctl", alu_ctl, 2);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_rsp0_data", rsp0_data, 12);
    chk("add_rsp0_zero", rsp0_zero, 0);
    chk("idle_alu_ctl", alu_ctl, 0);
    chk("idle_req0_ready", req0_ready, 0);

    // Round-robin; pointer now favours req1 after the req0 grant.
    @(negedge clk);
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd100; req0_b = 32'd23;
    req1_valid = 1'b1; req1_ctl = 4'd6; req1_a = 32'd3;   req1_b = 32'd3;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_req1_ready", req1_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_req0_ready", req0_ready, (i % 2 == 1) ? 1 : 0);
      @(negedge clk);
      if (i == 0) begin
        chk("rr_rsp1_valid", rsp1_valid, 1);
        chk("rr_rsp1_data", rsp1_data, 0);
        chk("rr_rsp1_zero", rsp1_zero, 1);
      end
      if (i == 1) begin
        chk("rr_rsp0_data", rsp0_data, 123);
      end
    end

    // Backpressure on rsp0 (holding 123): req1 SLT -1 < 1 wins every cycle.
    rsp0_ready = 1'b0;
    req1_ctl = 4'd7; req1_a = 32'hffff_ffff; req1_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready", req1_ready, 1);
      @(negedge clk);
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_rsp0_data", rsp0_data, 123);
      chk("bp_rsp1_data", rsp1_data, 1);
      chk("bp_rsp1_lt", rsp1_lt, 1);
      chk("bp_rsp1_ltu", rsp1_ltu, 0);
    end

    // Drain and refill rsp0 in one cycle.
    req1_valid = 1'b0;
    rsp0_ready = 1'b1; req0_a = 32'h10; req0_b = 32'h20;
    #1;
    chk("refill_req0_ready", req0_ready, 1);
    @(negedge clk);
    chk("refill_rsp0_valid", rsp0_valid, 1);
    chk("refill_rsp0_data", rsp0_data, 32'h30);
    chk("refill_rsp1_valid", rsp1_valid, 0);

    // Idle cycle: no grant, ALU port zero, rsp0 drains.
    req0_valid = 1'b0;
    #1;
    chk("idle2_req0_ready", req0_ready, 0);
    chk("idle2_alu_a", alu_a, 0);
    @(negedge clk);
    chk("idle2_rsp0_valid", rsp0_valid, 0);

    // Fill rsp1 (held), then req0 so the pointer ends on req1.
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd1; req1_b = 32'd2;
    rsp1_ready = 1'b0;
    #1;
    chk("fill_req1_ready", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd4; req0_b = 32'd4;
    #1;
    chk("fill_req0_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("fill_rsp0_data", rsp0_data, 8);
    chk("fill_rsp1_valid", rsp1_valid, 1);
    chk("fill_rsp1_data", rsp1_data, 3);

    // Asynchronous reset mid-cycle discards held responses at once.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rsp1_valid", rsp1_valid, 0);
    chk("async_rsp1_data", rsp1_data, 0);
    chk("async_rsp0_valid", rsp0_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp1_valid", rsp1_valid, 0);

    // First contention after reset goes to req0 (reset pointer).
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_ctl = 4'd6; req1_a = 32'd9; req1_b = 32'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("post_rst_req0_ready", req0_ready, 1);
    chk("post_rst_req1_ready", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("post_rst_rsp0_data", rsp0_data, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
